// File: rtl/mem_stack_stage_pkg.sv
// Shared definitions for the MEM stage: FSM state encoding and default sizes.
// No ports; imported by mem_stack_stage and stack_data_ram.
package mem_stack_stage_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MEM_DEPTH = 4096;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INT_HI = 3'd1,
    S_INT_LO = 3'd2,
    S_INT_FL = 3'd3,
    S_RTI_FL = 3'd4,
    S_RTI_LO = 3'd5,
    S_RTI_HI = 3'd6
  } state_t;

  function automatic logic is_save(state_t s);
    return (s == S_INT_HI) || (s == S_INT_LO) || (s == S_INT_FL);
  endfunction

  function automatic logic is_restore(state_t s);
    return (s == S_RTI_FL) || (s == S_RTI_LO) || (s == S_RTI_HI);
  endfunction

endpackage

// File: rtl/mem_stack_stage_ram.sv
// Data RAM: synchronous write port, combinational read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module stack_data_ram
  import mem_stack_stage_pkg::*;
#(
  parameter int DEPTH = DEF_MEM_DEPTH,
  parameter int DW    = DEF_DATA_W,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_stack_stage.sv
// MEM stage: RAM access, stack pointer, interrupt context save / RTI restore.
// Ports: EX/MEM inputs, MEM/WB register, stall, SP, int/rti handshake, fault.
module mem_stack_stage
  import mem_stack_stage_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int FLAG_W    = 4,
  parameter int SP_RESET  = MEM_DEPTH - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_rsrc_value,
  input  logic [DATA_W-1:0] ex_rdst_value,
  input  logic [2:0]        ex_rdst_addr,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_wb,
  input  logic              ex_push,
  input  logic              ex_pop,
  input  logic              int_req,
  input  logic              rti_req,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  output logic              stall,
  output logic [ADDR_W-1:0] sp_out,
  output logic              wb_valid,
  output logic              wb_mem_read,
  output logic              wb_wb,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [2:0]        wb_rdst_addr,
  output logic              int_ack,
  output logic              pc_restore_valid,
  output logic [ADDR_W-1:0] pc_restore,
  output logic [FLAG_W-1:0] flags_restore,
  output logic              stack_fault
);

  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] SP_TOP = ADDR_W'(MEM_DEPTH - 1);

  if (ADDR_W != 2 * DATA_W) begin : g_bad_addr_w
    $error("ADDR_W must equal 2*DATA_W");
  end
  if (FLAG_W > DATA_W) begin : g_bad_flag_w
    $error("FLAG_W must not exceed DATA_W");
  end

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W-1:0] sp_d;
  logic [ADDR_W-1:0] sp_inc;
  logic [ADDR_W-1:0] sp_dec;
  logic              wrap_up;
  logic              wrap_dn;

  logic [ADDR_W-1:0] pc_q;
  logic [FLAG_W-1:0] fl_q;

  logic              ram_we;
  logic [IW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [IW-1:0]     ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  logic              fault_d;
  logic              ex_go;
  logic              pop_only;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^ex_rdst_value[DATA_W-1:IW];

  // SP stays inside [0, MEM_DEPTH-1]; stepping past either end wraps.
  assign wrap_up = (sp_q == SP_TOP);
  assign wrap_dn = (sp_q == '0);
  assign sp_inc  = wrap_up ? '0 : sp_q + ADDR_W'(1);
  assign sp_dec  = wrap_dn ? SP_TOP : sp_q - ADDR_W'(1);

  assign ex_go    = (state_q == S_IDLE) && ex_valid;
  assign pop_only = ex_pop & ~ex_push;
  assign sp_out   = sp_q;

  stack_data_ram #(
    .DEPTH (MEM_DEPTH),
    .DW    (DATA_W),
    .IW    (IW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // int_req beats rti_req; requests outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (int_req) begin
          state_d = S_INT_HI;
        end else if (rti_req) begin
          state_d = S_RTI_FL;
        end
      end
      S_INT_HI: state_d = S_INT_LO;
      S_INT_LO: state_d = S_INT_FL;
      S_INT_FL: state_d = S_IDLE;
      S_RTI_FL: state_d = S_RTI_LO;
      S_RTI_LO: state_d = S_RTI_HI;
      S_RTI_HI: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall     = (state_q != S_IDLE);
    ram_we    = 1'b0;
    ram_waddr = sp_q[IW-1:0];
    ram_wdata = ex_rsrc_value;
    ram_raddr = sp_inc[IW-1:0];
    sp_d      = sp_q;
    fault_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          unique case (1'b1)
            ex_push: begin
              ram_we  = 1'b1;
              sp_d    = sp_dec;
              fault_d = wrap_dn;
            end
            pop_only: begin
              sp_d    = sp_inc;
              fault_d = wrap_up;
            end
            default: begin
              // load and store use separate ports, so a
              // combined op reads the pre-write word.
              ram_raddr = ex_rsrc_value[IW-1:0];
              ram_waddr = ex_rdst_value[IW-1:0];
              ram_we    = ex_mem_write;
            end
          endcase
        end
      end
      S_INT_HI, S_INT_LO, S_INT_FL: begin
        ram_we  = 1'b1;
        sp_d    = sp_dec;
        fault_d = wrap_dn;
        if (state_q == S_INT_HI) begin
          ram_wdata = pc_q[ADDR_W-1:DATA_W];
        end else if (state_q == S_INT_LO) begin
          ram_wdata = pc_q[DATA_W-1:0];
        end else begin
          ram_wdata             = '0;
          ram_wdata[FLAG_W-1:0] = fl_q;
        end
      end
      S_RTI_FL, S_RTI_LO, S_RTI_HI: begin
        sp_d    = sp_inc;
        fault_d = wrap_up;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= ADDR_W'(SP_RESET);
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      fl_q <= '0;
    end else if ((state_q == S_IDLE) && int_req) begin
      pc_q <= pc_in;
      fl_q <= flags_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_mem_read   <= 1'b0;
      wb_wb         <= 1'b0;
      wb_mem_data   <= '0;
      wb_alu_result <= '0;
      wb_rdst_addr  <= '0;
    end else begin
      wb_valid <= ex_go;
      if (ex_go) begin
        wb_mem_read   <= ex_mem_read | pop_only;
        wb_wb         <= ex_wb;
        wb_mem_data   <= ram_rdata;
        wb_alu_result <= ex_alu_result;
        wb_rdst_addr  <= ex_rdst_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_fault      <= 1'b0;
      int_ack          <= 1'b0;
      pc_restore_valid <= 1'b0;
      pc_restore       <= '0;
      flags_restore    <= '0;
    end else begin
      stack_fault      <= fault_d;
      int_ack          <= is_save(state_q) && (state_q == S_INT_FL);
      pc_restore_valid <= is_restore(state_q) && (state_q == S_RTI_HI);
      unique case (state_q)
        S_RTI_FL: flags_restore <= ram_rdata[FLAG_W-1:0];
        S_RTI_LO: pc_restore[DATA_W-1:0] <= ram_rdata;
        S_RTI_HI: pc_restore[ADDR_W-1:DATA_W] <= ram_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stack_stage.sv
// Randomized self-checking bench for mem_stack_stage.
// Reference model: flat memory array plus an integer stack pointer.
module tb_mem_stack_stage;

  localparam int DW    = 16;
  localparam int AW    = 32;
  localparam int DEPTH = 4096;
  localparam int FW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid;
  logic [DW-1:0] ex_alu_result;
  logic [DW-1:0] ex_rsrc_value;
  logic [DW-1:0] ex_rdst_value;
  logic [2:0]    ex_rdst_addr;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_wb;
  logic          ex_push;
  logic          ex_pop;
  logic          int_req;
  logic          rti_req;
  logic [AW-1:0] pc_in;
  logic [FW-1:0] flags_in;
  logic          stall;
  logic [AW-1:0] sp_out;
  logic          wb_valid;
  logic          wb_mem_read;
  logic          wb_wb;
  logic [DW-1:0] wb_mem_data;
  logic [DW-1:0] wb_alu_result;
  logic [2:0]    wb_rdst_addr;
  logic          int_ack;
  logic          pc_restore_valid;
  logic [AW-1:0] pc_restore;
  logic [FW-1:0] flags_restore;
  logic          stack_fault;

  mem_stack_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid         (ex_valid),
    .ex_alu_result    (ex_alu_result),
    .ex_rsrc_value    (ex_rsrc_value),
    .ex_rdst_value    (ex_rdst_value),
    .ex_rdst_addr     (ex_rdst_addr),
    .ex_mem_read      (ex_mem_read),
    .ex_mem_write     (ex_mem_write),
    .ex_wb            (ex_wb),
    .ex_push          (ex_push),
    .ex_pop           (ex_pop),
    .int_req          (int_req),
    .rti_req          (rti_req),
    .pc_in            (pc_in),
    .flags_in         (flags_in),
    .stall            (stall),
    .sp_out           (sp_out),
    .wb_valid         (wb_valid),
    .wb_mem_read      (wb_mem_read),
    .wb_wb            (wb_wb),
    .wb_mem_data      (wb_mem_data),
    .wb_alu_result    (wb_alu_result),
    .wb_rdst_addr     (wb_rdst_addr),
    .int_ack          (int_ack),
    .pc_restore_valid (pc_restore_valid),
    .pc_restore       (pc_restore),
    .flags_restore    (flags_restore),
    .stack_fault      (stack_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_known [DEPTH];
  int            ref_sp;

  logic          e_valid;
  logic          e_mr;
  logic          e_wb;
  logic          e_fault;
  logic [DW-1:0] e_data;
  logic [DW-1:0] e_alu;
  logic [2:0]    e_rd;
  bit            e_dchk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ex_valid      = 1'b0;
    ex_alu_result = '0;
    ex_rsrc_value = '0;
    ex_rdst_value = '0;
    ex_rdst_addr  = '0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_wb         = 1'b0;
    ex_push       = 1'b0;
    ex_pop        = 1'b0;
    int_req       = 1'b0;
    rti_req       = 1'b0;
    pc_in         = '0;
    flags_in      = '0;
  endtask

  task automatic model_reset();
    ref_sp  = DEPTH - 1;
    e_valid = 1'b0;
    e_mr    = 1'b0;
    e_wb    = 1'b0;
    e_fault = 1'b0;
    e_data  = '0;
    e_alu   = '0;
    e_rd    = '0;
    e_dchk  = 1'b1;
  endtask

  // One EX op against the model: stack grows downward, pop reads SP+1.
  task automatic model_ex();
    int a;
    e_valid = ex_valid;
    e_fault = 1'b0;
    if (!ex_valid) return;
    e_mr   = ex_mem_read | (ex_pop & ~ex_push);
    e_wb   = ex_wb;
    e_rd   = ex_rdst_addr;
    e_alu  = ex_alu_result;
    e_dchk = 1'b0;
    if (ex_push) begin
      ref_mem[ref_sp]   = ex_rsrc_value;
      ref_known[ref_sp] = 1'b1;
      e_fault = (ref_sp == 0);
      ref_sp  = (ref_sp + DEPTH - 1) % DEPTH;
    end else if (ex_pop) begin
      a       = (ref_sp + 1) % DEPTH;
      e_data  = ref_mem[a];
      e_dchk  = ref_known[a];
      e_fault = (ref_sp == DEPTH - 1);
      ref_sp  = a;
    end else if (ex_mem_read) begin
      a      = int'(ex_rsrc_value) % DEPTH;
      e_data = ref_mem[a];
      e_dchk = ref_known[a];
      if (ex_mem_write) begin
        ref_mem[int'(ex_rdst_value) % DEPTH]   = ex_rsrc_value;
        ref_known[int'(ex_rdst_value) % DEPTH] = 1'b1;
      end
    end else if (ex_mem_write) begin
      a            = int'(ex_rdst_value) % DEPTH;
      ref_mem[a]   = ex_rsrc_value;
      ref_known[a] = 1'b1;
    end
  endtask

  task automatic rand_ex();
    int op;
    op            = $urandom_range(0, 5);
    ex_valid      = ($urandom_range(0, 3) != 0);
    ex_alu_result = 16'($urandom);
    ex_rsrc_value = 16'($urandom);
    ex_rdst_value = 16'($urandom);
    ex_rdst_addr  = 3'($urandom);
    ex_wb         = 1'($urandom);
    ex_mem_read   = (op == 1);
    ex_mem_write  = (op == 2);
    ex_push       = (op == 3) || (op == 5);
    ex_pop        = (op == 4) || (op == 5);
    if (op == 1) ex_rsrc_value = {4'($urandom), 8'h00, 4'($urandom)};
    if (op == 2) ex_rdst_value = {4'($urandom), 8'h00, 4'($urandom)};
  endtask

  task automatic test_reset();
    clear_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stall, sp_out, wb_valid, wb_mem_read, wb_wb, wb_mem_data,
         wb_alu_result, wb_rdst_addr, int_ack, pc_restore_valid,
         pc_restore, flags_restore, stack_fault} !==
        {1'b0, 32'h0000_0FFF, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'h0,
         1'b0, 1'b0, 32'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset got stall=%b sp=%h wbv=%b alu=%h ack=%b exp stall=0 sp=00000fff rest 0",
               stall, sp_out, wb_valid, wb_alu_result, int_ack);
    end
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_store_load();
    clear_in();
    ex_valid = 1'b1; ex_mem_write = 1'b1;
    ex_rdst_value = 16'h0010; ex_rsrc_value = 16'hBEEF;
    ex_alu_result = 16'h1234; ex_rdst_addr = 3'd3;
    model_ex();
    tick();
    checks++;
    if ({wb_valid, wb_mem_read, wb_alu_result, wb_rdst_addr} !==
        {1'b1, 1'b0, 16'h1234, 3'd3}) begin
      errors++;
      $display("FAIL store_wb got v=%b mr=%b alu=%h rd=%0d exp 1 0 1234 3",
               wb_valid, wb_mem_read, wb_alu_result, wb_rdst_addr);
    end
    clear_in();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_wb = 1'b1;
    ex_rsrc_value = 16'h0010; ex_rdst_addr = 3'd5;
    model_ex();
    tick();
    checks++;
    if ({wb_valid, wb_mem_read, wb_wb, wb_mem_data, wb_rdst_addr} !==
        {1'b1, 1'b1, 1'b1, 16'hBEEF, 3'd5}) begin
      errors++;
      $display("FAIL load got v=%b mr=%b wb=%b data=%h rd=%0d exp 1 1 1 beef 5",
               wb_valid, wb_mem_read, wb_wb, wb_mem_data, wb_rdst_addr);
    end
    clear_in();
    model_ex();
    tick();
    checks++;
    if ({wb_valid, wb_mem_data, sp_out} !== {1'b0, 16'hBEEF, 32'h0FFF}) begin
      errors++;
      $display("FAIL bubble_hold got v=%b data=%h sp=%h exp 0 beef 00000fff",
               wb_valid, wb_mem_data, sp_out);
    end
  endtask

  task automatic test_push_pop();
    logic [DW-1:0] vals [2];
    logic [AW-1:0] sps [4];
    logic [DW-1:0] pops [2];
    vals[0] = 16'h1111; vals[1] = 16'h2222;
    sps[0] = 32'h0FFE; sps[1] = 32'h0FFD; sps[2] = 32'h0FFE; sps[3] = 32'h0FFF;
    pops[0] = 16'h2222; pops[1] = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      clear_in();
      ex_valid = 1'b1;
      ex_push = (i < 2);
      ex_pop  = (i >= 2);
      if (i < 2) ex_rsrc_value = vals[i];
      model_ex();
      tick();
      checks++;
      if (sp_out !== sps[i] || stack_fault !== 1'b0) begin
        errors++;
        $display("FAIL stack_sp step=%0d got sp=%h flt=%b exp %h 0",
                 i, sp_out, stack_fault, sps[i]);
      end
      if (i >= 2) begin
        checks++;
        if ({wb_valid, wb_mem_data} !== {1'b1, pops[i-2]}) begin
          errors++;
          $display("FAIL pop_data step=%0d got v=%b d=%h exp 1 %h",
                   i, wb_valid, wb_mem_data, pops[i-2]);
        end
      end
    end
  endtask

  task automatic test_int_save();
    logic [DW-1:0] w [3];
    w[0] = 16'h0001; w[1] = 16'h2345; w[2] = 16'h000A;
    clear_in();
    int_req = 1'b1; pc_in = 32'h0001_2345; flags_in = 4'hA;
    model_ex();
    tick();
    clear_in();
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL int_enter got stall=%b exp 1", stall);
    end
    for (int k = 0; k < 3; k++) begin
      ref_mem[ref_sp]   = w[k];
      ref_known[ref_sp] = 1'b1;
      ref_sp = (ref_sp + DEPTH - 1) % DEPTH;
      e_valid = 1'b0;
      tick();
      checks++;
      if ({stall, int_ack, wb_valid} !== {k < 2, k == 2, 1'b0}) begin
        errors++;
        $display("FAIL int_step k=%0d got stall=%b ack=%b v=%b", k, stall, int_ack, wb_valid);
      end
    end
    checks++;
    if ({sp_out, dut.u_ram.mem[4095], dut.u_ram.mem[4094], dut.u_ram.mem[4093]} !==
        {32'h0FFC, 16'h0001, 16'h2345, 16'h000A}) begin
      errors++;
      $display("FAIL int_mem got sp=%h fff=%h ffe=%h ffd=%h exp 00000ffc 0001 2345 000a",
               sp_out, dut.u_ram.mem[4095], dut.u_ram.mem[4094], dut.u_ram.mem[4093]);
    end
    tick();
    checks++;
    if (int_ack !== 1'b0) begin
      errors++;
      $display("FAIL int_ack_pulse got %b exp 0", int_ack);
    end
  endtask

  task automatic test_rti();
    clear_in();
    rti_req = 1'b1;
    model_ex();
    tick();
    clear_in();
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rti_enter got stall=%b exp 1", stall);
    end
    for (int k = 0; k < 3; k++) begin
      ref_sp = (ref_sp + 1) % DEPTH;
      tick();
      checks++;
      if ({stall, pc_restore_valid, wb_valid} !== {k < 2, k == 2, 1'b0}) begin
        errors++;
        $display("FAIL rti_step k=%0d got stall=%b prv=%b v=%b",
                 k, stall, pc_restore_valid, wb_valid);
      end
    end
    checks++;
    if ({pc_restore, flags_restore, sp_out} !== {32'h0001_2345, 4'hA, 32'h0FFF}) begin
      errors++;
      $display("FAIL rti_val got pc=%h fl=%h sp=%h exp 00012345 a 00000fff",
               pc_restore, flags_restore, sp_out);
    end
    tick();
    checks++;
    if (pc_restore_valid !== 1'b0) begin
      errors++;
      $display("FAIL rti_pulse got %b exp 0", pc_restore_valid);
    end
  endtask

  task automatic test_wrap();
    bit saw;
    saw = 1'b0;
    clear_in();
    ex_valid = 1'b1;
    ex_push  = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      ex_rsrc_value = 16'(i);
      model_ex();
      tick();
      if (stack_fault) saw = 1'b1;
    end
    checks++;
    if ({saw, sp_out} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL wrap_fill got fault_seen=%b sp=%h exp 0 00000000", saw, sp_out);
    end
    ex_rsrc_value = 16'hDEAD;
    model_ex();
    tick();
    checks++;
    if ({stack_fault, sp_out} !== {1'b1, 32'h0FFF}) begin
      errors++;
      $display("FAIL wrap_fault got flt=%b sp=%h exp 1 00000fff", stack_fault, sp_out);
    end
    clear_in();
    model_ex();
    tick();
    checks++;
    if (stack_fault !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pulse got %b exp 0", stack_fault);
    end
  endtask

  task automatic test_int_rti_conflict();
    logic [AW-1:0] pc;
    logic [FW-1:0] fl;
    logic [DW-1:0] w [3];
    pc = $urandom;
    fl = 4'($urandom);
    w[0] = pc[31:16]; w[1] = pc[15:0]; w[2] = {12'h0, fl};
    clear_in();
    int_req = 1'b1; rti_req = 1'b1; pc_in = pc; flags_in = fl;
    model_ex();
    tick();
    clear_in();
    for (int k = 0; k < 3; k++) begin
      ref_mem[ref_sp]   = w[k];
      ref_known[ref_sp] = 1'b1;
      ref_sp = (ref_sp + DEPTH - 1) % DEPTH;
      tick();
      checks++;
      if ({stall, int_ack, pc_restore_valid} !== {k < 2, k == 2, 1'b0}) begin
        errors++;
        $display("FAIL both_req k=%0d got stall=%b ack=%b prv=%b",
                 k, stall, int_ack, pc_restore_valid);
      end
    end
    checks++;
    if ({sp_out, dut.u_ram.mem[4095], dut.u_ram.mem[4094]} !==
        {32'h0FFC, pc[31:16], pc[15:0]}) begin
      errors++;
      $display("FAIL both_save got sp=%h hi=%h lo=%h exp 00000ffc %h",
               sp_out, dut.u_ram.mem[4095], dut.u_ram.mem[4094], pc);
    end
  endtask

  task automatic test_reset_mid_seq();
    bit saw;
    int idx;
    clear_in();
    int_req = 1'b1; pc_in = 32'hCAFE_F00D; flags_in = 4'h5;
    model_ex();
    tick();
    clear_in();
    idx = ref_sp;
    ref_mem[idx]   = 16'hCAFE;
    ref_known[idx] = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, sp_out, wb_valid, int_ack, pc_restore_valid, wb_alu_result,
         wb_mem_data, stack_fault} !==
        {1'b0, 32'h0FFF, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL midseq_reset got stall=%b sp=%h v=%b ack=%b alu=%h exp 0 00000fff 0 0 0",
               stall, sp_out, wb_valid, int_ack, wb_alu_result);
    end
    saw = 1'b0;
    repeat (3) begin
      tick();
      if (int_ack || stall) saw = 1'b1;
    end
    rst_n = 1'b1;
    model_reset();
    repeat (3) begin
      tick();
      if (int_ack || stall) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL midseq_ack got ack_or_stall_seen=%b exp 0", saw);
    end
    checks++;
    if (dut.u_ram.mem[idx] !== 16'hCAFE) begin
      errors++;
      $display("FAIL midseq_ram got %h exp cafe", dut.u_ram.mem[idx]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int kind;
      bit do_int;
      bit do_rti;
      bit kn;
      logic [DW-1:0] w [3];
      logic [DW-1:0] r [3];
      kind = $urandom_range(0, 15);
      rand_ex();
      int_req  = (kind == 0) || (kind == 2);
      rti_req  = (kind == 1) || (kind == 2);
      pc_in    = $urandom;
      flags_in = 4'($urandom);
      do_int = int_req;
      do_rti = rti_req && !int_req;
      w[0] = pc_in[31:16]; w[1] = pc_in[15:0]; w[2] = {12'h0, flags_in};
      model_ex();
      tick();
      checks++;
      if ({wb_valid, wb_mem_read, wb_wb, wb_rdst_addr, wb_alu_result, sp_out,
           stack_fault, stall, int_ack, pc_restore_valid} !==
          {e_valid, e_mr, e_wb, e_rd, e_alu, 32'(ref_sp),
           e_fault, do_int | do_rti, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rand_wb n=%0d got v=%b mr=%b wb=%b rd=%0d alu=%h sp=%h f=%b st=%b exp %b %b %b %0d %h %h %b %b",
                 n, wb_valid, wb_mem_read, wb_wb, wb_rdst_addr, wb_alu_result,
                 sp_out, stack_fault, stall, e_valid, e_mr, e_wb, e_rd, e_alu,
                 32'(ref_sp), e_fault, do_int | do_rti);
      end
      if (e_dchk) begin
        checks++;
        if (wb_mem_data !== e_data) begin
          errors++;
          $display("FAIL rand_data n=%0d got %h exp %h", n, wb_mem_data, e_data);
        end
      end
      if (do_int || do_rti) begin
        kn = 1'b1;
        for (int k = 0; k < 3; k++) begin
          rand_ex();
          int_req = ($urandom_range(0, 2) == 0);
          rti_req = ($urandom_range(0, 2) == 0);
          e_valid = 1'b0;
          if (do_int) begin
            ref_mem[ref_sp]   = w[k];
            ref_known[ref_sp] = 1'b1;
            e_fault = (ref_sp == 0);
            ref_sp  = (ref_sp + DEPTH - 1) % DEPTH;
          end else begin
            e_fault = (ref_sp == DEPTH - 1);
            ref_sp  = (ref_sp + 1) % DEPTH;
            r[k]    = ref_mem[ref_sp];
            kn      = kn && ref_known[ref_sp];
          end
          tick();
          checks++;
          if ({stall, wb_valid, sp_out, stack_fault, int_ack, pc_restore_valid} !==
              {k < 2, 1'b0, 32'(ref_sp), e_fault, do_int && k == 2, do_rti && k == 2}) begin
            errors++;
            $display("FAIL rand_seq n=%0d k=%0d got st=%b v=%b sp=%h f=%b ack=%b prv=%b exp sp=%h f=%b",
                     n, k, stall, wb_valid, sp_out, stack_fault, int_ack,
                     pc_restore_valid, 32'(ref_sp), e_fault);
          end
        end
        if (do_rti && kn) begin
          checks++;
          if ({pc_restore, flags_restore} !== {r[2], r[1], r[0][FW-1:0]}) begin
            errors++;
            $display("FAIL rand_rti n=%0d got pc=%h fl=%h exp %h%h %h",
                     n, pc_restore, flags_restore, r[2], r[1], r[0][FW-1:0]);
          end
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_store_load();
    test_push_pop();
    test_int_save();
    test_rti();
    test_wrap();
    test_int_rti_conflict();
    test_reset_mid_seq();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
